// File: rtl/rv_mop_fission.sv
// rv_mop_fission -- splits a decoded, possibly fused, RISC-V macro-op into
// one or two micro-ops for the downstream issue stage.
//
// Ports
//   clock, reset_n                 clock and asynchronous active-low reset
//   in_valid / in_ready            upstream handshake for one decoded op
//   in_rd, in_rs1, in_rs2          register fields of the incoming op
//   in_opcode, in_funct3,
//   in_funct7, in_imm              opcode[6:2], function fields, 33-bit
//                                  signed immediate
//   flush                          kills the buffered op and any pending uop
//   out_valid / out_ready          downstream handshake for one micro-op
//   out_rd .. out_imm              micro-op fields
//   out_last                       final micro-op of the current op
//   out_illegal                    op not crackable / immediate not
//                                  representable
//
// Fused ops (opcode 00010) are cracked as:
//   funct7 0000000  load.pc     -> auipc rd,hi ; load rd,lo(rd)
//   funct7 0000001  load.add    -> add rd,rs1,rs2 ; load rd,0(rd)
//   funct7 00000{10,11,100}     -> shNadd rd,rs1,rs2 ; load rd,0(rd)
//   funct7 0000101, funct3 000  -> sub rd,x0,rs1 ; max rd,rd,rs1  (abs)
// Anything else under 00010 passes through flagged illegal; all other
// opcodes pass through unchanged as a single micro-op.
module rv_mop_fission (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [4:0]         in_opcode,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic signed [32:0] in_imm,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [4:0]         out_opcode,
  output logic [2:0]         out_funct3,
  output logic [6:0]         out_funct7,
  output logic signed [31:0] out_imm,
  output logic               out_last,
  output logic               out_illegal
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_UOP0  = 2'd1;
  localparam logic [1:0] S_UOP1  = 2'd2;

  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_FUSED = 5'b00010;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_OP    = 5'b01100;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        last;
    logic        illegal;
  } uop_t;

  // Upper part for auipc: bump hi20 when the low half is negative so that
  // hi + sext(lo) reconstructs the original value (wraps mod 2^32).
  function automatic logic [31:0] imm_hi_f(input logic signed [32:0] imm);
    logic [19:0] hi;
    hi = imm[31:12] + {19'b0, imm[11]};
    return {hi, 12'b0};
  endfunction

  function automatic logic [31:0] imm_lo_f(input logic signed [32:0] imm);
    return {{20{imm[11]}}, imm[11:0]};
  endfunction

  // Not representable: value outside signed 32 bits, or the hi20 rounding
  // carries 0x7FFFF into 0x80000 (positive value turning negative).
  function automatic logic imm_ovf_f(input logic signed [32:0] imm);
    return (imm[32] != imm[31]) || ((imm[31:12] == 20'h7FFFF) && imm[11]);
  endfunction

  logic [1:0] state;
  logic       rdy_en;
  uop_t       cur_p0;
  uop_t       nxt_p1;
  uop_t       uop0_d;
  uop_t       uop1_d;
  uop_t       ld_d;
  logic       accept;
  logic       fire;
  logic       ovf;

  assign out_valid = (state != S_EMPTY);
  assign fire      = out_valid && out_ready;
  // rdy_en keeps in_ready low until the first edge after reset release.
  assign in_ready  = rdy_en && !flush &&
                     ((state == S_EMPTY) || (fire && cur_p0.last));
  assign accept    = in_valid && in_ready;
  assign ovf       = imm_ovf_f(in_imm);

  // Decode: build both micro-ops from the incoming op
  always_comb begin
    uop0_d         = '0;
    uop0_d.rd      = in_rd;
    uop0_d.rs1     = in_rs1;
    uop0_d.rs2     = in_rs2;
    uop0_d.opcode  = in_opcode;
    uop0_d.funct3  = in_funct3;
    uop0_d.funct7  = in_funct7;
    uop0_d.imm     = in_imm[31:0];
    uop0_d.last    = 1'b1;
    uop0_d.illegal = 1'b0;

    uop1_d         = '0;
    uop1_d.last    = 1'b1;

    // Common second half of the load-fusion family: load rd, 0(rd).
    ld_d           = '0;
    ld_d.opcode    = OPC_LOAD;
    ld_d.funct3    = in_funct3;
    ld_d.rd        = in_rd;
    ld_d.rs1       = in_rd;
    ld_d.last      = 1'b1;

    if (in_opcode == OPC_FUSED) begin
      uop0_d.illegal = 1'b1;
      case (in_funct7)
        7'b0000000: begin
          uop0_d         = '0;
          uop0_d.opcode  = OPC_AUIPC;
          uop0_d.rd      = in_rd;
          uop0_d.imm     = imm_hi_f(in_imm);
          uop0_d.illegal = ovf;
          uop1_d         = ld_d;
          uop1_d.imm     = imm_lo_f(in_imm);
          uop1_d.illegal = ovf;
        end
        7'b0000001, 7'b0000010, 7'b0000011, 7'b0000100: begin
          uop0_d        = '0;
          uop0_d.opcode = OPC_OP;
          uop0_d.rd     = in_rd;
          uop0_d.rs1    = in_rs1;
          uop0_d.rs2    = in_rs2;
          case (in_funct7[2:0])
            3'b010:  uop0_d.funct3 = 3'b010;
            3'b011:  uop0_d.funct3 = 3'b100;
            3'b100:  uop0_d.funct3 = 3'b110;
            default: uop0_d.funct3 = 3'b000;
          endcase
          uop0_d.funct7 = (in_funct7 == 7'b0000001) ? 7'b0000000 : 7'b0010000;
          uop1_d        = ld_d;
        end
        7'b0000101: begin
          if (in_funct3 == 3'b000) begin
            uop0_d        = '0;
            uop0_d.opcode = OPC_OP;
            uop0_d.funct7 = 7'b0100000;
            uop0_d.rd     = in_rd;
            uop0_d.rs2    = in_rs1;
            uop1_d        = '0;
            uop1_d.opcode = OPC_OP;
            uop1_d.funct3 = 3'b110;
            uop1_d.funct7 = 7'b0000101;
            uop1_d.rd     = in_rd;
            uop1_d.rs1    = in_rd;
            uop1_d.rs2    = in_rs1;
            uop1_d.last   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0: presented micro-op and control state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_EMPTY;
      rdy_en <= 1'b0;
      cur_p0 <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (flush) begin
        state <= S_EMPTY;
      end else if (accept) begin
        state  <= S_UOP0;
        cur_p0 <= uop0_d;
      end else if (fire && !cur_p0.last) begin
        state  <= S_UOP1;
        cur_p0 <= nxt_p1;
      end else if (fire) begin
        state <= S_EMPTY;
      end
    end
  end

  // Stage p1: second micro-op waiting behind the presented one
  always_ff @(posedge clock) begin
    if (accept) begin
      nxt_p1 <= uop1_d;
    end
  end

  assign out_rd      = cur_p0.rd;
  assign out_rs1     = cur_p0.rs1;
  assign out_rs2     = cur_p0.rs2;
  assign out_opcode  = cur_p0.opcode;
  assign out_funct3  = cur_p0.funct3;
  assign out_funct7  = cur_p0.funct7;
  assign out_imm     = cur_p0.imm;
  assign out_last    = cur_p0.last;
  assign out_illegal = cur_p0.illegal;

endmodule

// File: tb/tb_rv_mop_fission.sv
module tb_rv_mop_fission;

  logic               clock = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [4:0]         in_rd, in_rs1, in_rs2, in_opcode;
  logic [2:0]         in_funct3;
  logic [6:0]         in_funct7;
  logic signed [32:0] in_imm;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [4:0]         out_rd, out_rs1, out_rs2, out_opcode;
  logic [2:0]         out_funct3;
  logic [6:0]         out_funct7;
  logic signed [31:0] out_imm;
  logic               out_last;
  logic               out_illegal;

  int checks = 0;
  int errors = 0;

  rv_mop_fission dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_last(out_last), .out_illegal(out_illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_uop(input string tag, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm, input logic last,
                         input logic ill);
    chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    chk(tag, {out_rd, out_rs1, out_rs2, out_opcode, out_funct3, out_funct7,
              out_imm, out_last, out_illegal},
             {rd, rs1, rs2, opc, f3, f7, imm, last, ill});
  endtask

  task automatic issue(input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic signed [32:0] imm);
    in_valid  = 1'b1;
    in_opcode = opc;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {out_valid, out_rd, out_rs1, out_rs2, out_opcode, out_funct3, out_funct7,
              out_imm, out_last, out_illegal, in_ready}, '0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    issue(5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 33'sd5);
    #12;
    chk_idle("reset_idle");
    @(negedge clock); reset_n = 1'b1;
    #1 chk("ready_before_edge", {63'b0, in_ready}, 64'd0);
    @(posedge clock);
    #1 chk("ready_after_edge", {63'b0, in_ready}, 64'd1);
    in_valid = 1'b0;

    // load.pc ld x5, 0x1800 -> auipc x5,0x2000 ; ld x5,-2048(x5)
    @(negedge clock); out_ready = 1'b1;
    issue(5'b00010, 3'd3, 7'd0, 5'd5, 5'd9, 5'd9, 33'sh0_0000_1800);
    #1 chk("pc_in_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clock); in_valid = 1'b0;
    #1 chk_uop("pc_uop0", 5'd5, 5'd0, 5'd0, 5'b00101, 3'd0, 7'd0, 32'h0000_2000, 1'b0, 1'b0);
    chk("pc_ready_mid", {63'b0, in_ready}, 64'd0);
    @(negedge clock);
    #1 chk_uop("pc_uop1", 5'd5, 5'd5, 5'd0, 5'b00000, 3'd3, 7'd0, 32'hFFFF_F800, 1'b1, 1'b0);
    chk("pc_ready_last", {63'b0, in_ready}, 64'd1);
    @(negedge clock);
    #1 chk("pc_drained", {63'b0, out_valid}, 64'd0);

    // load.sh2add with out_ready low three cycles
    out_ready = 1'b0;
    issue(5'b00010, 3'd2, 7'd3, 5'd10, 5'd11, 5'd12, 33'sd0);
    @(negedge clock); in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk_uop("sh2_hold", 5'd10, 5'd11, 5'd12, 5'b01100, 3'b100, 7'b0010000, 32'd0, 1'b0, 1'b0);
      chk("sh2_ready_hold", {63'b0, in_ready}, 64'd0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1 chk_uop("sh2_uop0", 5'd10, 5'd11, 5'd12, 5'b01100, 3'b100, 7'b0010000, 32'd0, 1'b0, 1'b0);
    chk("sh2_ready_uop0", {63'b0, in_ready}, 64'd0);
    @(negedge clock);
    #1 chk_uop("sh2_uop1", 5'd10, 5'd10, 5'd0, 5'b00000, 3'd2, 7'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clock);

    // abs x7, x8
    issue(5'b00010, 3'd0, 7'd5, 5'd7, 5'd8, 5'd3, 33'sd0);
    @(negedge clock); in_valid = 1'b0;
    #1 chk_uop("abs_sub", 5'd7, 5'd0, 5'd8, 5'b01100, 3'b000, 7'b0100000, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    #1 chk_uop("abs_max", 5'd7, 5'd7, 5'd8, 5'b01100, 3'b110, 7'b0000101, 32'd0, 1'b1, 1'b0);
    @(negedge clock);

    // back-to-back addi x1,x0,5
    issue(5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 33'sd5);
    #1 chk("addi_ready0", {63'b0, in_ready}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1 chk_uop("addi_stream", 5'd1, 5'd0, 5'd0, 5'b00100, 3'd0, 7'd0, 32'd5, 1'b1, 1'b0);
      chk("addi_ready", {63'b0, in_ready}, 64'd1);
    end
    in_valid = 1'b0;
    @(negedge clock);
    #1 chk("addi_drained", {63'b0, out_valid}, 64'd0);

    // flush while in UOP1 (load.add)
    issue(5'b00010, 3'd3, 7'd1, 5'd2, 5'd3, 5'd4, 33'sd0);
    @(negedge clock); in_valid = 1'b0;
    #1 chk_uop("ladd_uop0", 5'd2, 5'd3, 5'd4, 5'b01100, 3'd0, 7'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clock);
    #1 chk_uop("ladd_uop1", 5'd2, 5'd2, 5'd0, 5'b00000, 3'd3, 7'd0, 32'd0, 1'b1, 1'b0);
    flush = 1'b1;
    issue(5'b00100, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 33'sd9);
    #1 chk("flush_ready", {63'b0, in_ready}, 64'd0);
    @(negedge clock); flush = 1'b0;
    #1 chk("flush_valid", {63'b0, out_valid}, 64'd0);
    chk("flush_ready_after", {63'b0, in_ready}, 64'd1);
    @(negedge clock); in_valid = 1'b0;
    #1 chk_uop("flush_next", 5'd1, 5'd0, 5'd0, 5'b00100, 3'd0, 7'd0, 32'd9, 1'b1, 1'b0);
    @(negedge clock);

    // load.pc rounding overflow
    issue(5'b00010, 3'd2, 7'd0, 5'd6, 5'd0, 5'd0, 33'sh0_7FFF_F800);
    @(negedge clock); in_valid = 1'b0;
    #1 chk_uop("ovf_uop0", 5'd6, 5'd0, 5'd0, 5'b00101, 3'd0, 7'd0, 32'h8000_0000, 1'b0, 1'b1);
    @(negedge clock);
    #1 chk_uop("ovf_uop1", 5'd6, 5'd6, 5'd0, 5'b00000, 3'd2, 7'd0, 32'hFFFF_F800, 1'b1, 1'b1);
    @(negedge clock);

    // load.pc with 33-bit range violation and rd=x0
    issue(5'b00010, 3'd3, 7'd0, 5'd0, 5'd0, 5'd0, 33'sh1_0000_0000);
    @(negedge clock); in_valid = 1'b0;
    #1 chk_uop("rng_uop0", 5'd0, 5'd0, 5'd0, 5'b00101, 3'd0, 7'd0, 32'd0, 1'b0, 1'b1);
    @(negedge clock);
    #1 chk_uop("rng_uop1", 5'd0, 5'd0, 5'd0, 5'b00000, 3'd3, 7'd0, 32'd0, 1'b1, 1'b1);
    @(negedge clock);

    // unknown fused encoding passes through flagged illegal
    issue(5'b00010, 3'd1, 7'd7, 5'd3, 5'd4, 5'd5, 33'sh0_0000_0123);
    @(negedge clock); in_valid = 1'b0;
    #1 chk_uop("bad_fused", 5'd3, 5'd4, 5'd5, 5'b00010, 3'd1, 7'd7, 32'h0000_0123, 1'b1, 1'b1);
    @(negedge clock);

    // reset in UOP1 discards the second micro-op
    issue(5'b00010, 3'd3, 7'd1, 5'd2, 5'd3, 5'd4, 33'sd0);
    @(negedge clock); in_valid = 1'b0;
    @(negedge clock);
    #1 chk("rst_pre_last", {63'b0, out_last}, 64'd1);
    reset_n = 1'b0;
    #1 chk_idle("rst_mid");
    @(negedge clock); reset_n = 1'b1;
    #1 chk_idle("rst_release");
    @(posedge clock);
    #1 chk("rst_ready", {out_valid, in_ready}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
